fpu_result_buffer: RTL and testbench
====================================

Name: fpu_result_buffer

Overview:
- Sits directly downstream of the pipelined FP32 adder.
- Captures every result/valid_out beat and classifies each result (NaN, Inf, zero, subnormal, sign).
- Queues results in a small FIFO and presents them to the TinyQV peripheral read side through a valid/ready handshake.
- The adder has no backpressure, so the block also reports free slots; the issuer gates valid_in with this count and must include results still in flight in the adder.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- DATA_W, 32, result width; fixed FP32 layout.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy and free-slot counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  adder valid_out; push strobe.
- in_result  in  DATA_W  adder result.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head this cycle.
- out_result  out  DATA_W  head result.
- out_flags  out  5  head flags {sign, subnormal, zero, inf, nan}; nan is bit 0.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- free_slots  out  CNT_W  DEPTH - count.
- overflow  out  1  sticky: a push was dropped.
- clear_overflow  in  1  clears the sticky overflow bit.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - Next cycle: out_valid = 0, out_result = 0, out_flags = 0, free_slots = DEPTH.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries and any push or pop in that cycle.
- Storage: each entry holds {flags[4:0], result[31:0]}. Flags are computed at push time from in_result, never at pop time.
- Classification, with exp = bits[30:23] and man = bits[22:0]:
  - nan = exp==8'hFF and man!=0
  - inf = exp==8'hFF and man==0
  - zero = exp==0 and man==0
  - subnormal = exp==0 and man!=0
  - sign = bit 31; set for -0 and for negative NaN
  - nan, inf, zero and subnormal are mutually exclusive; all four are 0 for normal numbers.
- Push and pop:
  - pop = out_valid and out_ready.
  - push = in_valid and (count < DEPTH or pop).
- Read side:
  - out_valid = (count != 0).
  - out_result and out_flags are driven combinationally from the head entry.
  - Both are forced to 0 when empty.
  - out_result and out_flags must hold stable while out_valid=1 and out_ready=0.
- Latency: a pushed result appears on out_* the cycle after the push edge; the FIFO has no bypass.
- Simultaneous push and pop:
  - When empty: no pop is possible; the push proceeds, count becomes 1.
  - When full: both proceed, count stays DEPTH, nothing is dropped, overflow is unchanged.
  - Otherwise: count is unchanged and both pointers advance.
- Overflow:
  - in_valid=1 while count==DEPTH and no pop → entry dropped, overflow set to 1, pointers and count unchanged.
  - A set event and clear_overflow in the same cycle → set wins.
  - clear_overflow alone → overflow becomes 0 next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits wide and wrap modulo DEPTH naturally; full and empty are distinguished by count, not by pointer compare.
- out_ready while empty has no effect.
- X-safety: in_result is ignored when in_valid=0; no flag or state change results.

Decomposition:
- Package fpu_pkg (shared with the adder):
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23, EXP_MAX=8'hFF.
  - Flag bit indices: FLG_NAN=0, FLG_INF=1, FLG_ZERO=2, FLG_SUB=3, FLG_SIGN=4.
  - Typedef fp_flags_t as a 5-bit packed struct.
  - Canonical constants: QNAN=32'h7FC00000, PINF=32'h7F800000.
- Sub-module fpu_classify: purely combinational, DATA_W result in, fp_flags_t out. It is reused by later FPU stages (mul, compare).
- The FIFO core stays inline.

Test Plan:
- Reset, then push 32'h3F800000 (1.0) with out_ready=0 → next cycle: out_valid=1, out_result=32'h3F800000, out_flags=0, count=1, free_slots=3; held stable for 3 cycles; pop → out_valid=0, out_result=0.
- Push 32'h7FC00000, 32'hFF800000, 32'h80000000 and 32'h00000001 on consecutive cycles, then drain → flags 5'b00001, 5'b10010, 5'b10100, 5'b01000, in order.
- Fill 4 entries, then in_valid=1 with out_ready=0 → value dropped, overflow=1, count=4. Drain → the original 4 come out in order. Assert clear_overflow together with another overflow event → overflow stays 1; clear_overflow alone → overflow=0.
- With the FIFO full, push 32'h40000000 and assert out_ready in the same cycle → head popped, new value enqueued at the tail, count=4, overflow=0.
- Continuous stream of 20 pushes with out_ready toggling 1,0,1,0 → all values that were accepted come out in order. Pointers wrap past DEPTH with no loss, and count never exceeds 4.
- Assert rst with 3 entries queued and in_valid=1 → next cycle: count=0, out_valid=0, overflow=0; the next push appears as the sole entry.

Source files
------------

// File: rtl/fpu_pkg.sv
// FP32 field layout, flag encoding and canonical constants shared by the FPU stages.
package fpu_pkg;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MAN_W    = 23;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  localparam int unsigned FLG_NAN  = 0;
  localparam int unsigned FLG_INF  = 1;
  localparam int unsigned FLG_ZERO = 2;
  localparam int unsigned FLG_SUB  = 3;
  localparam int unsigned FLG_SIGN = 4;
  localparam int unsigned FLG_W    = 5;

  // Bit order matches FLG_* indices: nan is bit 0, sign is bit 4.
  typedef struct packed {
    logic sign;
    logic sub;
    logic zero;
    logic inf;
    logic nan;
  } fp_flags_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

endpackage : fpu_pkg

// File: rtl/fpu_classify.sv
// Combinational FP32 classifier: NaN / Inf / zero / subnormal / sign.
module fpu_classify
  import fpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_result,
  output fp_flags_t         o_flags
);

  logic [7:0]       w_exp;
  logic [MAN_W-1:0] w_man;
  logic             w_exp_max;
  logic             w_exp_zero;
  logic             w_man_zero;
  logic [FLG_W-1:0] w_vec;

  assign w_exp      = i_result[EXP_MSB:EXP_LSB];
  assign w_man      = i_result[MAN_W-1:0];
  assign w_exp_max  = (w_exp == EXP_MAX);
  assign w_exp_zero = (w_exp == 8'h00);
  assign w_man_zero = (w_man == '0);

  // Exponent/mantissa class decode; the four classes are mutually exclusive.
  always_comb begin
    w_vec           = '0;
    w_vec[FLG_NAN]  = w_exp_max  & ~w_man_zero;
    w_vec[FLG_INF]  = w_exp_max  &  w_man_zero;
    w_vec[FLG_ZERO] = w_exp_zero &  w_man_zero;
    w_vec[FLG_SUB]  = w_exp_zero & ~w_man_zero;
    w_vec[FLG_SIGN] = i_result[SIGN_BIT];
  end

  assign o_flags = fp_flags_t'(w_vec);

endmodule : fpu_classify

// File: rtl/fpu_result_buffer.sv
// Result FIFO behind the FP32 adder: classifies each result at push time,
// queues {flags, result} and presents the head through valid/ready.
module fpu_result_buffer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_flags,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  free_slots,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_data [DEPTH];
  fp_flags_t         r_flg  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  fp_flags_t         w_in_flags;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count_nxt;

  fpu_classify #(
    .DATA_W (DATA_W)
  ) u_classify (
    .i_result (in_result),
    .o_flags  (w_in_flags)
  );

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = ~w_empty & out_ready;
  assign w_push  = in_valid & (~w_full | w_pop);
  assign w_drop  = in_valid & w_full & ~w_pop;

  // Occupancy update; a full-and-pop push keeps the count at DEPTH.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers and occupancy; pointers wrap modulo DEPTH by width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Entry storage, no reset needed; writes are suppressed during reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_data[r_wr_ptr] <= in_result;
      r_flg[r_wr_ptr]  <= w_in_flags;
    end
  end

  // Sticky overflow; a new drop takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_valid  = ~w_empty;
  assign out_result = w_empty ? '0   : r_data[r_rd_ptr];
  assign out_flags  = w_empty ? 5'b0 : r_flg[r_rd_ptr];
  assign count      = r_count;
  assign free_slots = CNT_W'(DEPTH) - r_count;
  assign overflow   = r_overflow;

endmodule : fpu_result_buffer

// File: tb/tb_fpu_result_buffer.sv
// Scoreboard bench for fpu_result_buffer: directed pushes carry hand-computed
// flags into a queue; a negedge monitor checks the head and occupancy each cycle.
module tb_fpu_result_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [31:0]      in_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_flags;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free_slots;
  logic             overflow;
  logic             clear_overflow;

  logic [4:0]       exp_flags;
  logic [36:0]      sb[$];
  int               mcount;
  int               n_cmp  = 0;
  int               n_fail = 0;

  fpu_result_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_result      (in_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_flags      (out_flags),
    .count          (count),
    .free_slots     (free_slots),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; idle cycles drive a junk result to show it is ignored.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] f,
                      input logic rdy, input logic clr);
    in_valid       = v;
    in_result      = d;
    exp_flags      = f;
    out_ready      = rdy;
    clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h7F80_0000, 5'b0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("drained_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic fill4(input logic [31:0] base);
    for (int i = 0; i < 4; i++) step(1'b1, base + 32'(i), 5'b0, 1'b0, 1'b0);
  endtask

  // Monitor: checks head/occupancy against the scoreboard, then tracks this edge's push/pop.
  initial begin
    logic pop_m;
    logic push_m;
    mcount = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        mcount = 0;
      end else begin
        chk("out_valid", 32'(out_valid), 32'(mcount != 0));
        chk("count", 32'(count), 32'(mcount));
        chk("free_slots", 32'(free_slots), 32'(DEPTH - 32'(mcount)));
        if (mcount != 0 && sb.size() > 0) begin
          chk("head_result", out_result, sb[0][31:0]);
          chk("head_flags", 32'(out_flags), 32'(sb[0][36:32]));
        end else begin
          chk("empty_result", out_result, 32'd0);
          chk("empty_flags", 32'(out_flags), 32'd0);
        end
        pop_m  = (mcount != 0) && out_ready;
        push_m = in_valid && ((mcount < 4) || pop_m);
        if (pop_m && sb.size() > 0) void'(sb.pop_front());
        if (push_m) sb.push_back({exp_flags, in_result});
        mcount = mcount + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sp_val[4] = '{32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000, 32'h0000_0001};
    logic [4:0]  sp_flg[4] = '{5'b00001, 5'b10010, 5'b10100, 5'b01000};

    rst = 1'b1; in_valid = 1'b0; in_result = '0; exp_flags = '0;
    out_ready = 1'b0; clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_free", 32'(free_slots), 32'd4);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Single normal value, held for three stalled cycles, then popped.
    step(1'b1, 32'h3F80_0000, 5'b00000, 1'b0, 1'b0);
    chk("one_count", 32'(count), 32'd1);
    chk("one_free", 32'(free_slots), 32'd3);
    chk("one_result", out_result, 32'h3F80_0000);
    repeat (3) idle(1'b0);
    idle(1'b1);
    chk("one_popped_valid", 32'(out_valid), 32'd0);
    chk("one_popped_result", out_result, 32'd0);

    // Special values: qNaN, -Inf, -0, smallest subnormal.
    for (int i = 0; i < 4; i++) step(1'b1, sp_val[i], sp_flg[i], 1'b0, 1'b0);
    chk("sp_count", 32'(count), 32'd4);
    drain();

    // Overflow: drop on full, set beats clear, clear alone.
    fill4(32'h3F00_0000);
    step(1'b1, 32'hDEAD_BEEF, 5'b10000, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    step(1'b1, 32'hDEAD_BEEF, 5'b10000, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    step(1'b0, 32'h0, 5'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    drain();

    // Full with simultaneous push and pop.
    fill4(32'h3E00_0000);
    step(1'b1, 32'h4000_0000, 5'b00000, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), 32'd4);
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    drain();

    // Stream of 20 with ready toggling; negative odd entries carry only the sign flag.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1) step(1'b1, 32'hC100_0000 + 32'(i), 5'b10000, 1'b0, 1'b0);
      else            step(1'b1, 32'h4100_0000 + 32'(i), 5'b00000, 1'b1, 1'b0);
    end
    drain();
    step(1'b0, 32'h0, 5'b0, 1'b0, 1'b1);

    // Reset with three queued, overflow set and a push in the reset cycle.
    fill4(32'h4200_0000);
    step(1'b1, 32'h4300_0000, 5'b0, 1'b0, 1'b0);
    idle(1'b1);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    rst = 1'b1;
    step(1'b1, 32'h4400_0000, 5'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    step(1'b1, 32'hBF80_0000, 5'b10000, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_result", out_result, 32'hBF80_0000);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fpu_result_buffer
